// File: rtl/sonic_pkg.sv
// Shared state encoding, default timing constants and LFSR step for the sonic echo responder.
// Pure definitions; no latency and no flow control.
package sonic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        BURST,
        ECHO,
        HOLDOFF
    } state_t;

    localparam int DEF_TICKS_PER_US   = 100;
    localparam int DEF_MIN_TRIG_US    = 10;
    localparam int DEF_BURST_DELAY_US = 250;
    localparam int DEF_US_PER_CM      = 58;
    localparam int DEF_MAX_DIST_CM    = 400;
    localparam int DEF_TIMEOUT_US     = 38000;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, maximal length
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; 2 clk latency.
// No flow control; flops clear on synchronous active-high rst.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sonic_echo_responder.sv
// Ultrasonic ranger emulator: qualified trigger -> fixed burst delay -> echo pulse sized by distance.
// Echo rises BURST_DELAY after the synchronized trigger fall; triggers during a measurement are ignored.
// Optional SONIC_ECHO_JITTER_EN adds 0-15 us of LFSR-driven echo extension.
module sonic_echo_responder
    import sonic_pkg::*;
#(
    parameter int TICKS_PER_US   = DEF_TICKS_PER_US,
    parameter int MIN_TRIG_US    = DEF_MIN_TRIG_US,
    parameter int BURST_DELAY_US = DEF_BURST_DELAY_US,
    parameter int US_PER_CM      = DEF_US_PER_CM,
    parameter int MAX_DIST_CM    = DEF_MAX_DIST_CM,
    parameter int TIMEOUT_US     = DEF_TIMEOUT_US
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig,
    input  logic [19:0] dist_cm,
    output logic        echo,
    output logic        busy,
    output logic        out_of_range,
    output logic [7:0]  trig_count
);

    localparam logic [31:0] MIN_W       = 32'(MIN_TRIG_US * TICKS_PER_US);
    localparam logic [31:0] BURST_CYC   = 32'(BURST_DELAY_US * TICKS_PER_US);
    localparam logic [31:0] TIMEOUT_CYC = 32'(TIMEOUT_US * TICKS_PER_US);
    localparam logic [31:0] CM_CYC      = 32'(US_PER_CM * TICKS_PER_US);

    state_t      state, state_nxt;
    logic        trig_s, trig_d, trig_rise, accept;
    logic [31:0] width_cnt, cyc_cnt, base_len, echo_len;
    logic [19:0] dist_lat;

    function automatic logic dist_ok(input logic [19:0] d);
        return (d != 20'd0) && (32'(d) <= 32'(MAX_DIST_CM));
    endfunction

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (trig),
        .q   (trig_s)
    );

    // Edge-based start means a trigger still high when we reach IDLE must drop first
    assign trig_rise = trig_s & ~trig_d;
    assign busy      = (state == BURST) || (state == ECHO) || (state == HOLDOFF);

    // In range the product is bounded by MAX_DIST_CM*US_PER_CM*TICKS_PER_US, so 32 bits is exact
    assign base_len = dist_ok(dist_lat) ? 32'(dist_lat) * CM_CYC : TIMEOUT_CYC;

`ifdef SONIC_ECHO_JITTER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (accept) begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    assign echo_len = base_len + 32'(lfsr[3:0]) * 32'(TICKS_PER_US);
`else
    assign echo_len = base_len;
`endif

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE:    if (trig_rise) state_nxt = TRIG_HI;
            TRIG_HI: begin
                if (!trig_s) begin
                    if (width_cnt >= MIN_W) begin
                        state_nxt = BURST;
                        accept    = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            BURST:   if (cyc_cnt == BURST_CYC - 32'd1) state_nxt = ECHO;
            ECHO:    if (cyc_cnt == echo_len - 32'd1) state_nxt = HOLDOFF;
            HOLDOFF: if (cyc_cnt == MIN_W - 32'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            trig_d       <= 1'b0;
            width_cnt    <= 32'd0;
            cyc_cnt      <= 32'd0;
            dist_lat     <= 20'd0;
            echo         <= 1'b0;
            out_of_range <= 1'b0;
            trig_count   <= 8'd0;
        end else begin
            state  <= state_nxt;
            trig_d <= trig_s;
            echo   <= (state_nxt == ECHO);

            if (state != TRIG_HI) begin
                width_cnt <= 32'd0;
            end else if (trig_s) begin
                width_cnt <= width_cnt + 32'd1;
            end

            if ((state_nxt != state) || !busy) begin
                cyc_cnt <= 32'd0;
            end else begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end

            if (accept) begin
                dist_lat     <= dist_cm;
                trig_count   <= trig_count + 8'd1;
                out_of_range <= !dist_ok(dist_cm);
            end
        end
    end

endmodule

// File: tb/tb_sonic_echo_responder.sv
// Bench for sonic_echo_responder with timing scaled down (2 ticks/us) so every scenario stays short.
// Expected timing and widths come from a distance-to-width model and a reference LFSR.
module tb_sonic_echo_responder;

    localparam int T        = 2;
    localparam int MIN_US   = 3;
    localparam int BURST_US = 5;
    localparam int UPC      = 3;
    localparam int MAXD     = 20;
    localparam int TO_US    = 70;

    localparam int MIN_W  = MIN_US * T;
    localparam int B_CYC  = BURST_US * T;
    localparam int H_CYC  = MIN_US * T;
    localparam int TO_CYC = TO_US * T;
    localparam int LIMIT  = 2000;
`ifdef SONIC_ECHO_JITTER_EN
    localparam int JIT = 1;
`else
    localparam int JIT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        trig;
    logic [19:0] dist_cm;
    logic        echo, busy, out_of_range;
    logic [7:0]  trig_count;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_count;
    logic [15:0] ref_lfsr;

    always #5 clk = ~clk;

    sonic_echo_responder #(
        .TICKS_PER_US   (T),
        .MIN_TRIG_US    (MIN_US),
        .BURST_DELAY_US (BURST_US),
        .US_PER_CM      (UPC),
        .MAX_DIST_CM    (MAXD),
        .TIMEOUT_US     (TO_US)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .trig         (trig),
        .dist_cm      (dist_cm),
        .echo         (echo),
        .busy         (busy),
        .out_of_range (out_of_range),
        .trig_count   (trig_count)
    );

    // Reference: an accepted trigger bumps the count and steps the jitter LFSR
    task automatic note_accept();
        exp_count = (exp_count + 1) % 256;
        ref_lfsr  = ref_lfsr[0] ? ((ref_lfsr >> 1) ^ 16'hB400) : (ref_lfsr >> 1);
    endtask

    function automatic int model_len(input int d);
        int len;
        len = (d == 0 || d > MAXD) ? TO_CYC : d * UPC * T;
        return len + JIT * int'(ref_lfsr[3:0]) * T;
    endfunction

    function automatic bit model_oor(input int d);
        return (d == 0 || d > MAXD);
    endfunction

    task automatic do_pulse(input int w, input logic [19:0] d);
        @(negedge clk);
        dist_cm = d;
        trig    = 1'b1;
        repeat (w) @(negedge clk);
        trig = 1'b0;
    endtask

    // Called right after trig drops: fall-to-echo delay, echo width, holdoff length
    task automatic measure(output int dly, output int wid, output int hold, output logic oor);
        dly = -1; wid = -1; hold = -1; oor = 1'bx;
        for (int i = 1; i <= LIMIT; i++) begin
            @(posedge clk); #1;
            if (echo) begin dly = i; break; end
        end
        if (dly < 0) return;
        oor = out_of_range;
        wid = 1;
        for (int i = 0; i < LIMIT; i++) begin
            @(posedge clk); #1;
            if (!echo) break;
            wid++;
        end
        hold = 0;
        for (int i = 0; i < LIMIT; i++) begin
            @(posedge clk); #1;
            hold++;
            if (!busy) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; trig = 1'b0; dist_cm = 20'd0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (echo !== 1'b0) begin n_bad++; $display("FAIL reset_echo: got %b want 0", echo); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (out_of_range !== 1'b0) begin n_bad++; $display("FAIL reset_oor: got %b want 0", out_of_range); end
        n_cmp++; if (trig_count !== 8'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", trig_count); end
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
        ref_lfsr  = 16'hACE1;
    endtask

    task automatic check_trigger(input string name, input int w, input int d);
        int dly, wid, hold; logic oor; int exp_w;
        do_pulse(w, 20'(d));
        note_accept();
        exp_w = model_len(d);
        measure(dly, wid, hold, oor);
        n_cmp++; if (dly !== B_CYC + 3) begin n_bad++; $display("FAIL %s_delay: got %0d want %0d", name, dly, B_CYC + 3); end
        n_cmp++; if (wid !== exp_w) begin n_bad++; $display("FAIL %s_width: got %0d want %0d (dist %0d)", name, wid, exp_w, d); end
        n_cmp++; if (hold !== H_CYC) begin n_bad++; $display("FAIL %s_holdoff: got %0d want %0d", name, hold, H_CYC); end
        n_cmp++; if (oor !== model_oor(d)) begin n_bad++; $display("FAIL %s_oor: got %b want %b", name, oor, model_oor(d)); end
        n_cmp++; if (trig_count !== 8'(exp_count)) begin n_bad++; $display("FAIL %s_count: got %0d want %0d", name, trig_count, exp_count); end
    endtask

    task automatic test_short_trigger(input int w);
        bit seen = 0;
        @(negedge clk);
        dist_cm = 20'd5;
        trig    = 1'b1;
        for (int i = 0; i < w + 20; i++) begin
            if (i == w) trig = 1'b0;
            @(posedge clk); #1;
            if (busy || echo) seen = 1;
            @(negedge clk);
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL short_busy: got activity want none (width %0d)", w); end
        n_cmp++; if (trig_count !== 8'(exp_count)) begin n_bad++; $display("FAIL short_count: got %0d want %0d", trig_count, exp_count); end
    endtask

    task automatic test_boundaries();
        check_trigger("dist0", MIN_W + 2, 0);
        check_trigger("dist_over", MIN_W + 2, MAXD + 1);
        check_trigger("dist_max", MIN_W + 2, MAXD);
        check_trigger("dist1", MIN_W + 2, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 3) == 0)
                test_short_trigger(int'($urandom_range(1, MIN_W - 1)));
            else
                check_trigger("rand", int'($urandom_range(MIN_W + 2, MIN_W + 12)), int'($urandom_range(0, MAXD + 5)));
        end
    endtask

    task automatic test_retrigger();
        int d, exp_w, dly, wid, hold; logic oor; bit seen;
        d = int'($urandom_range(4, MAXD));
        do_pulse(MIN_W + 2, 20'(d));
        note_accept();
        exp_w = model_len(d);
        dly = -1;
        for (int i = 1; i <= LIMIT; i++) begin
            @(posedge clk); #1;
            if (echo) begin dly = i; break; end
        end
        wid = (dly < 0) ? -1 : 1;
        for (int i = 0; i < LIMIT && dly >= 0; i++) begin
            @(posedge clk); #1;
            if (!echo) break;
            wid++;
            trig = (wid >= 2 && wid < MIN_W + 4);
            if (wid == 4) dist_cm = 20'(MAXD + 7);
        end
        trig = 1'b0;
        n_cmp++; if (wid !== exp_w) begin n_bad++; $display("FAIL retrig_width: got %0d want %0d", wid, exp_w); end
        n_cmp++; if (out_of_range !== 1'b0) begin n_bad++; $display("FAIL retrig_oor: got %b want 0", out_of_range); end
        n_cmp++; if (trig_count !== 8'(exp_count)) begin n_bad++; $display("FAIL retrig_count: got %0d want %0d", trig_count, exp_count); end
        // Raise trig during holdoff and keep it high into IDLE: must not start a new cycle
        for (int i = 0; i < LIMIT; i++) begin
            @(posedge clk); #1;
            trig = 1'b1;
            if (!busy) break;
        end
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy) seen = 1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL held_trig_busy: got activity want none"); end
        n_cmp++; if (trig_count !== 8'(exp_count)) begin n_bad++; $display("FAIL held_trig_count: got %0d want %0d", trig_count, exp_count); end
        @(negedge clk);
        trig = 1'b0;
        repeat (4) @(negedge clk);
        check_trigger("after_held", MIN_W + 3, 3);
    endtask

    task automatic test_reset_mid_echo();
        int dly, wid, hold; logic oor;
        do_pulse(MIN_W + 2, 20'd0);
        for (int i = 1; i <= LIMIT; i++) begin
            @(posedge clk); #1;
            if (echo) break;
        end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (echo !== 1'b0) begin n_bad++; $display("FAIL midrst_echo: got %b want 0", echo); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_cmp++; if (out_of_range !== 1'b0) begin n_bad++; $display("FAIL midrst_oor: got %b want 0", out_of_range); end
        n_cmp++; if (trig_count !== 8'd0) begin n_bad++; $display("FAIL midrst_count: got %0d want 0", trig_count); end
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
        ref_lfsr  = 16'hACE1;
        check_trigger("post_rst", MIN_W + 4, 4);
    endtask

    task automatic test_wrap();
        int dly, wid, hold; logic oor; int exp_w;
        for (int n = 0; n < 256; n++) begin
            do_pulse(MIN_W + 2, 20'd1);
            note_accept();
            exp_w = model_len(1);
            measure(dly, wid, hold, oor);
            n_cmp++; if (wid !== exp_w) begin n_bad++; $display("FAIL wrap_width[%0d]: got %0d want %0d", n, wid, exp_w); end
            if (n == 254) begin
                n_cmp++; if (trig_count !== 8'd255) begin n_bad++; $display("FAIL wrap_255: got %0d want 255", trig_count); end
            end
        end
        n_cmp++; if (trig_count !== 8'd0) begin n_bad++; $display("FAIL wrap_zero: got %0d want 0", trig_count); end
    endtask

    initial begin
        test_reset();
        check_trigger("nominal", 2 * MIN_W, 10);
        test_short_trigger(MIN_W - 1);
        test_boundaries();
        test_random();
        test_retrigger();
        test_reset_mid_echo();
        test_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sonic_echo_responder.md
SONIC_ECHO_RESPONDER -- requirements
Module: sonic_echo_responder

Interface
REQ-001 SHALL have parameter TICKS_PER_US, default 100, clk cycles per microsecond.
REQ-002 SHALL have parameter MIN_TRIG_US, default 10, minimum accepted trigger width in µs.
REQ-003 SHALL have parameter BURST_DELAY_US, default 250, delay from trigger fall to echo rise in µs.
REQ-004 SHALL have parameter US_PER_CM, default 58, echo µs per cm of distance.
REQ-005 SHALL have parameters MAX_DIST_CM, default 400, and TIMEOUT_US, default 38000.
REQ-006 SHALL have port clk, input, 1, single system clock.
REQ-007 SHALL have port rst, input, 1, reset; one clock, reset synchronous and active-high.
REQ-008 SHALL have port trig, input, 1, asynchronous trigger from the ranging initiator.
REQ-009 SHALL have port dist_cm, input, 20, emulated target distance in cm.
REQ-010 SHALL have port echo, output, 1, echo pulse to the initiator.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE and TRIG_HI.
REQ-012 SHALL have port out_of_range, output, 1, set when the current echo uses TIMEOUT_US.
REQ-013 SHALL have port trig_count, output, 8, count of accepted triggers.

Function
REQ-014 SHALL pass trig through a 2-flop synchronizer; all edges below refer to the synchronized signal.
REQ-015 SHALL implement states IDLE, TRIG_HI, BURST, ECHO, HOLDOFF.
REQ-016 IDLE->TRIG_HI on trig rise; the width counter starts at 0.
REQ-017 TRIG_HI: count cycles while high; on fall, go to BURST if width >= MIN_TRIG_US*TICKS_PER_US, else go to IDLE with no other effect.
REQ-018 On an accepted fall, SHALL latch dist_cm and increment trig_count modulo 256 (255->0).
REQ-019 BURST SHALL last exactly BURST_DELAY_US*TICKS_PER_US cycles, then go to ECHO.
REQ-020 echo SHALL be registered and high exactly for the cycles spent in ECHO.
REQ-021 ECHO length SHALL be latched_dist*US_PER_CM*TICKS_PER_US cycles; the product is computed at least 32 bits wide with no truncation.
REQ-022 If latched_dist==0 or >MAX_DIST_CM, ECHO length SHALL be TIMEOUT_US*TICKS_PER_US cycles and out_of_range SHALL be 1 from BURST entry until the next accepted trigger.
REQ-023 After ECHO, SHALL spend MIN_TRIG_US*TICKS_PER_US cycles in HOLDOFF, then go to IDLE.
REQ-024 trig edges in BURST, ECHO or HOLDOFF SHALL be ignored; a trig already high on return to IDLE SHALL NOT start TRIG_HI until it has been seen low.
REQ-025 dist_cm changes after the latch SHALL NOT affect the echo in progress.

Reset
REQ-026 rst SHALL force IDLE, echo=0, busy=0, out_of_range=0, trig_count=0, all counters 0, synchronizer flops 0; it takes effect at the next clk edge, including mid-ECHO.

Configuration
REQ-027 With SONIC_ECHO_JITTER_EN defined, ECHO SHALL be extended by lfsr[3:0]*TICKS_PER_US cycles (0-15 µs). The value SHALL come from a 16-bit maximal LFSR (seed 16'hACE1 at reset) that advances once per accepted trigger. The extension SHALL be applied also in the timeout case.
REQ-028 Without SONIC_ECHO_JITTER_EN, the LFSR SHALL be absent and echo width SHALL be exact per REQ-021/022.

Structure
REQ-029 Shared package sonic_pkg SHALL hold the state enum typedef and the default timing constants (100, 10, 250, 58, 400, 38000).
REQ-030 The synchronizer SHALL be a sub-module sync_2ff; the FSM, counters and LFSR stay in sonic_echo_responder.

Verification (TICKS_PER_US=100, jitter off unless stated)
REQ-031 dist_cm=10, trig high 12 µs -> echo rises 25000 cycles after the synchronized fall, width 58000 cycles, trig_count=1, out_of_range=0.
REQ-032 trig high 5 µs -> no echo, busy stays 0, trig_count unchanged.
REQ-033 dist_cm=0, then dist_cm=401 -> each echo width 3,800,000 cycles, out_of_range=1; dist_cm=400 -> width 2,320,000, out_of_range=0.
REQ-034 Second 12 µs trig during ECHO, and dist_cm changed mid-echo -> the echo in progress is unaffected, trig_count unchanged.
REQ-035 rst pulsed mid-ECHO -> echo=0 and all outputs at reset values one cycle later; a subsequent valid trig produces a normal echo.
REQ-036 256 valid triggers -> trig_count wraps to 0; with SONIC_ECHO_JITTER_EN, width = 58000 + lfsr[3:0]*100, checked against a reference LFSR model.
